// File: rtl/rggen_apb_bridge.sv
// Host-request to APB master bridge: IDLE -> SETUP -> ACCESS -> RESPONSE, one request at a time.
// Optional ACCESS-phase timeout is compiled in with `define RGGEN_APB_BRIDGE_TIMEOUT_EN.
module rggen_apb_bridge #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic                     i_write,
   input  logic [ADDRESS_WIDTH-1:0] i_address,
   input  logic [BUS_WIDTH-1:0]     i_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_strobe,
   output logic                     o_ready,
   output logic [BUS_WIDTH-1:0]     o_read_data,
   output logic [1:0]               o_status,
   output logic                     o_psel,
   output logic                     o_penable,
   output logic                     o_pwrite,
   output logic [ADDRESS_WIDTH-1:0] o_paddr,
   output logic [BUS_WIDTH-1:0]     o_pwdata,
   output logic [BUS_WIDTH/8-1:0]   o_pstrb,
   input  logic                     i_pready,
   input  logic [BUS_WIDTH-1:0]     i_prdata,
   input  logic                     i_pslverr
);

   localparam logic [1:0] StatusOkay    = 2'b00;
   localparam logic [1:0] StatusSlverr  = 2'b10;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
   localparam logic [1:0] StatusTimeout = 2'b11;
   localparam int         CountWidth    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CountWidth-1:0] TimeoutCount = CountWidth'(TIMEOUT_CYCLES);
`endif

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResponse
   } state_e;

   state_e                   state_q, state_d;
   logic                     pwrite_q, pwrite_d;
   logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
   logic [BUS_WIDTH-1:0]     pwdata_q, pwdata_d;
   logic [BUS_WIDTH/8-1:0]   pstrb_q, pstrb_d;
   logic                     ready_q, ready_d;
   logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
   logic [1:0]               status_q, status_d;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
   logic [CountWidth-1:0]    count_q, count_d, count_inc;

   assign count_inc = count_q + CountWidth'(1);
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         ready_q     <= 1'b0;
         read_data_q <= '0;
         status_q    <= StatusOkay;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
         count_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         ready_q     <= ready_d;
         read_data_q <= read_data_d;
         status_q    <= status_d;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
         count_q     <= count_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      ready_d     = 1'b0;
      read_data_d = read_data_q;
      status_d    = status_q;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
      count_d     = count_q;
`endif
      unique case (state_q)
         StIdle: begin
            // Host fields are only sampled here, so they stay frozen for the whole transfer.
            if (i_valid) begin
               pwrite_d = i_write;
               paddr_d  = i_address;
               pwdata_d = i_write_data;
               pstrb_d  = i_strobe;
               state_d  = StSetup;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
               count_d  = '0;
`endif
            end
         end
         StSetup: begin
            state_d = StAccess;
         end
         StAccess: begin
            if (i_pready) begin
               read_data_d = pwrite_q ? '0 : i_prdata;
               status_d    = i_pslverr ? StatusSlverr : StatusOkay;
               ready_d     = 1'b1;
               state_d     = StResponse;
            end
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
            // A late pready wins over the timeout because it is tested first.
            else if (count_inc == TimeoutCount) begin
               read_data_d = '0;
               status_d    = StatusTimeout;
               ready_d     = 1'b1;
               state_d     = StResponse;
            end else begin
               count_d = count_inc;
            end
`endif
         end
         StResponse: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_psel    = 1'b0;
      o_penable = 1'b0;
      unique case (state_q)
         StSetup:  o_psel = 1'b1;
         StAccess: begin
            o_psel    = 1'b1;
            o_penable = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_pwrite    = pwrite_q;
   assign o_paddr     = paddr_q;
   assign o_pwdata    = pwdata_q;
   assign o_pstrb     = pstrb_q;
   assign o_ready     = ready_q;
   assign o_read_data = read_data_q;
   assign o_status    = status_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Self-checking bench for rggen_apb_bridge; expected timing derived from the transfer-level model.
// Define RGGEN_APB_BRIDGE_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_rggen_apb_bridge;

   localparam int AW = 16;
   localparam int BW = 32;
   localparam int SW = BW / 8;
   localparam int TimeoutCycles = 4;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0;
   logic          write = 1'b0;
   logic [AW-1:0] address = '0;
   logic [BW-1:0] write_data = '0;
   logic [SW-1:0] strobe = '0;
   logic          ready;
   logic [BW-1:0] read_data;
   logic [1:0]    status;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [BW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic          pready = 1'b0;
   logic [BW-1:0] prdata = '0;
   logic          pslverr = 1'b0;

   int checks = 0;
   int errors = 0;

   // Current request and the slave behaviour it will see.
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [BW-1:0] req_wdata;
   logic [SW-1:0] req_strb;
   int            req_waits;
   logic [BW-1:0] req_prdata;
   logic          req_slverr;

   rggen_apb_bridge #(
      .ADDRESS_WIDTH  (AW),
      .BUS_WIDTH      (BW),
      .TIMEOUT_CYCLES (TimeoutCycles)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (valid),
      .i_write      (write),
      .i_address    (address),
      .i_write_data (write_data),
      .i_strobe     (strobe),
      .o_ready      (ready),
      .o_read_data  (read_data),
      .o_status     (status),
      .o_psel       (psel),
      .o_penable    (penable),
      .o_pwrite     (pwrite),
      .o_paddr      (paddr),
      .o_pwdata     (pwdata),
      .o_pstrb      (pstrb),
      .i_pready     (pready),
      .i_prdata     (prdata),
      .i_pslverr    (pslverr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req();
      valid      = 1'b1;
      write      = req_write;
      address    = req_addr;
      write_data = req_wdata;
      strobe     = req_strb;
   endtask

   task automatic scramble_host();
      write      = 1'($urandom);
      address    = AW'($urandom);
      write_data = $urandom;
      strobe     = SW'($urandom);
   endtask

   task automatic random_apb();
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
   endtask

   task automatic random_req(input int max_waits);
      req_write  = 1'($urandom);
      req_addr   = AW'($urandom);
      req_wdata  = $urandom;
      req_strb   = SW'($urandom);
      req_waits  = int'($urandom_range(max_waits, 0));
      req_prdata = $urandom;
      req_slverr = 1'($urandom);
   endtask

   // Runs one transfer whose request is already on the host inputs. Cycle c counts post-edge
   // observations after the accepting edge: c=0 SETUP, 1..acc ACCESS, acc+1 response, acc+2 idle.
   task automatic run_xfer(input string name, input bit hold_next, input int next_max_waits);
      logic          w     = req_write;
      logic [AW-1:0] addr  = req_addr;
      logic [BW-1:0] wdata = req_wdata;
      logic [SW-1:0] strb  = req_strb;
      int            waits = req_waits;
      logic [BW-1:0] prd   = req_prdata;
      logic          slv   = req_slverr;
      bit            tout  = TimeoutEn && (waits >= TimeoutCycles);
      int            acc   = tout ? TimeoutCycles : waits + 1;
      logic [BW-1:0] exp_rdata  = (tout || w) ? '0 : prd;
      logic [1:0]    exp_status = tout ? 2'b11 : (slv ? 2'b10 : 2'b00);
      logic          exp_psel, exp_pen, exp_ready;
      random_apb();
      for (int c = 0; c <= acc + 2; c++) begin
         tick();
         exp_psel  = (c <= acc);
         exp_pen   = (c >= 1) && (c <= acc);
         exp_ready = (c == acc + 1);
         checks++;
         if (psel !== exp_psel || penable !== exp_pen || ready !== exp_ready) begin
            errors++;
            $display("FAIL %s handshake c=%0d: psel/penable/ready got %b%b%b expected %b%b%b",
                     name, c, psel, penable, ready, exp_psel, exp_pen, exp_ready);
         end
         if (exp_psel) begin
            checks++;
            if ({pwrite, paddr, pwdata, pstrb} !== {w, addr, wdata, strb}) begin
               errors++;
               $display("FAIL %s apb_fields c=%0d: got w=%b a=%h d=%h s=%h expected w=%b a=%h d=%h s=%h",
                        name, c, pwrite, paddr, pwdata, pstrb, w, addr, wdata, strb);
            end
         end
         if (exp_ready) begin
            checks++;
            if (read_data !== exp_rdata) begin
               errors++;
               $display("FAIL %s read_data: got %h expected %h", name, read_data, exp_rdata);
            end
            checks++;
            if (status !== exp_status) begin
               errors++;
               $display("FAIL %s status: got %b expected %b", name, status, exp_status);
            end
         end
         // Stimulus for the next edge.
         if (c == 0) scramble_host();
         if (c >= 1 && c <= acc) begin
            pready  = (c == waits + 1);
            pslverr = (c == waits + 1) ? slv : 1'($urandom);
            prdata  = (c == waits + 1) ? prd : $urandom;
         end else begin
            random_apb();
         end
         if (c == acc + 1) begin
            if (hold_next) begin
               random_req(next_max_waits);
               drive_req();
            end else begin
               valid = 1'b0;
               scramble_host();
            end
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      valid = 1'b1;
      scramble_host();
      random_apb();
      repeat (3) tick();
      checks++;
      if ({psel, penable, ready, status} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got psel=%b pen=%b rdy=%b st=%b expected all 0",
                  psel, penable, ready, status);
      end
      checks++;
      if ({pwrite, paddr, pwdata, pstrb} !== '0) begin
         errors++;
         $display("FAIL reset_apb: got w=%b a=%h d=%h s=%h expected 0", pwrite, paddr, pwdata, pstrb);
      end
      checks++;
      if (read_data !== '0) begin
         errors++;
         $display("FAIL reset_rdata: got %h expected 0", read_data);
      end
      rst   = 1'b0;
      valid = 1'b0;
      tick();
   endtask

   task automatic test_zero_wait_write();
      req_write = 1'b1; req_addr = 16'h0010; req_wdata = 32'hDEADBEEF; req_strb = 4'hF;
      req_waits = 0; req_prdata = 32'hA5A5A5A5; req_slverr = 1'b0;
      drive_req();
      run_xfer("zero_wait_write", 1'b0, 0);
   endtask

   task automatic test_wait_read();
      req_write = 1'b0; req_addr = 16'h0024; req_wdata = 32'h0; req_strb = 4'h0;
      req_waits = 3; req_prdata = 32'h12345678; req_slverr = 1'b0;
      drive_req();
      run_xfer("wait_read", 1'b0, 0);
   endtask

   task automatic test_slverr();
      req_write = 1'b0; req_addr = 16'h0100; req_wdata = 32'h0; req_strb = 4'h0;
      req_waits = 1; req_prdata = 32'hCAFEF00D; req_slverr = 1'b1;
      drive_req();
      run_xfer("slverr_read", 1'b0, 0);
      req_write = 1'b1; req_addr = 16'h0104; req_wdata = 32'h0BADC0DE; req_strb = 4'h3;
      req_waits = 0; req_prdata = 32'hFFFFFFFF; req_slverr = 1'b1;
      drive_req();
      run_xfer("slverr_write", 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      random_req(2);
      drive_req();
      run_xfer("b2b_first", 1'b1, 2);
      run_xfer("b2b_second", 1'b1, 2);
      run_xfer("b2b_third", 1'b0, 0);
   endtask

   task automatic test_reset_abort();
      req_write = 1'b0; req_addr = 16'h0200; req_wdata = 32'h0; req_strb = 4'h0;
      drive_req();
      pready = 1'b0;
      tick();
      scramble_host();
      tick();
      checks++;
      if (psel !== 1'b1 || penable !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_access: got psel=%b pen=%b expected 11", psel, penable);
      end
      rst    = 1'b1;
      pready = 1'b1;
      tick();
      checks++;
      if ({psel, penable, ready, paddr} !== '0) begin
         errors++;
         $display("FAIL abort_reset: got psel=%b pen=%b rdy=%b a=%h expected all 0",
                  psel, penable, ready, paddr);
      end
      rst   = 1'b0;
      valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         random_apb();
         tick();
         checks++;
         if (ready !== 1'b0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet c=%0d: got rdy=%b psel=%b expected 0 0", i, ready, psel);
         end
      end
   endtask

   // Long wait times out only when the feature is compiled in; pready on the last allowed cycle
   // always completes normally.
   task automatic test_timeout();
      req_write = 1'b0; req_addr = 16'h0300; req_wdata = 32'h0; req_strb = 4'h0;
      req_waits = 10; req_prdata = 32'h55AA55AA; req_slverr = 1'b0;
      drive_req();
      run_xfer("timeout_long_wait", 1'b0, 0);
      req_waits = TimeoutCycles - 1; req_prdata = 32'h87654321; req_addr = 16'h0304;
      drive_req();
      run_xfer("timeout_edge_pready", 1'b0, 0);
   endtask

   task automatic test_random();
      bit hold;
      random_req(6);
      drive_req();
      for (int i = 0; i < 24; i++) begin
         hold = (i != 23) && 1'($urandom);
         run_xfer("random", hold, 6);
         if (!hold && i != 23) begin
            random_req(6);
            drive_req();
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait_write();
      test_wait_read();
      test_slverr();
      test_back_to_back();
      test_reset_abort();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
